execute_stage: RTL and testbench

- Execute stage of the 5-stage RV32 pipeline, directly downstream of the decode stage.
- Owns the decode-to-execute pipeline register, with synchronous reset and flush.
- Contains the operand forwarding muxes, the ALU, and branch/jump resolution.
- Sends PCSrcE/PCTargetE back to fetch. Sends the E-stage controls and data on to the memory stage.

---
 rtl/execute_stage.sv | 141 ++++++++++++++
 tb/tb_execute_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// RV32 execute stage: owns the D->E register, does forwarding, runs the ALU and resolves branches/jumps.
// Outputs appear one cycle after the D inputs. There is no stall: the E register loads every cycle.
// The optional branch statistics counters are enabled by defining EXEC_BRANCH_STATS_EN.
module execute_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             RegWriteD,
   input  logic             MemWriteD,
   input  logic             JumpD,
   input  logic             BranchD,
   input  logic             ALUSrcD,
   input  logic             JALRctrlD,
   input  logic [1:0]       ResultSrcD,
   input  logic [2:0]       ALUControlD,
   input  logic [WIDTH-1:0] RD1D,
   input  logic [WIDTH-1:0] RD2D,
   input  logic [WIDTH-1:0] PCD,
   input  logic [WIDTH-1:0] ImmExtD,
   input  logic [WIDTH-1:0] PCPlus4D,
   input  logic [4:0]       RdD,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic             FlushE,
   input  logic [1:0]       ForwardAE,
   input  logic [1:0]       ForwardBE,
   input  logic [WIDTH-1:0] ALUResultM,
   input  logic [WIDTH-1:0] ResultW,
   output logic             RegWriteE,
   output logic             MemWriteE,
   output logic [1:0]       ResultSrcE,
   output logic [4:0]       RdE,
   output logic [4:0]       Rs1E,
   output logic [4:0]       Rs2E,
   output logic [WIDTH-1:0] ALUResultE,
   output logic [WIDTH-1:0] WriteDataE,
   output logic [WIDTH-1:0] PCPlus4E,
   output logic [WIDTH-1:0] PCTargetE,
   output logic             PCSrcE,
   output logic             ZeroE
`ifdef EXEC_BRANCH_STATS_EN
  ,output logic [WIDTH-1:0] BranchCountE,
   output logic [WIDTH-1:0] TakenCountE
`endif
);

   logic             JumpE, BranchE, ALUSrcE, JALRctrlE;
   logic [2:0]       ALUControlE;
   logic [WIDTH-1:0] RD1E, RD2E, PCE, ImmExtE;
   logic [WIDTH-1:0] SrcAE, SrcBE, FwdBE;

   // A flush produces the same all-zero bubble as reset.
   always_ff @(posedge clk) begin
      if (rst || FlushE) begin
         RegWriteE   <= 1'b0;
         MemWriteE   <= 1'b0;
         JumpE       <= 1'b0;
         BranchE     <= 1'b0;
         ALUSrcE     <= 1'b0;
         JALRctrlE   <= 1'b0;
         ResultSrcE  <= 2'b00;
         ALUControlE <= 3'b000;
         RD1E        <= '0;
         RD2E        <= '0;
         PCE         <= '0;
         ImmExtE     <= '0;
         PCPlus4E    <= '0;
         RdE         <= 5'd0;
         Rs1E        <= 5'd0;
         Rs2E        <= 5'd0;
      end else begin
         RegWriteE   <= RegWriteD;
         MemWriteE   <= MemWriteD;
         JumpE       <= JumpD;
         BranchE     <= BranchD;
         ALUSrcE     <= ALUSrcD;
         JALRctrlE   <= JALRctrlD;
         ResultSrcE  <= ResultSrcD;
         ALUControlE <= ALUControlD;
         RD1E        <= RD1D;
         RD2E        <= RD2D;
         PCE         <= PCD;
         ImmExtE     <= ImmExtD;
         PCPlus4E    <= PCPlus4D;
         RdE         <= RdD;
         Rs1E        <= Rs1D;
         Rs2E        <= Rs2D;
      end
   end

   // Encoding 11 is reserved and falls back to the register-file value.
   always_comb begin
      case (ForwardAE)
         2'b01:   SrcAE = ResultW;
         2'b10:   SrcAE = ALUResultM;
         default: SrcAE = RD1E;
      endcase
      case (ForwardBE)
         2'b01:   FwdBE = ResultW;
         2'b10:   FwdBE = ALUResultM;
         default: FwdBE = RD2E;
      endcase
      SrcBE = ALUSrcE ? ImmExtE : FwdBE;
   end

   assign WriteDataE = FwdBE;

   always_comb begin
      case (ALUControlE)
         3'b000:  ALUResultE = SrcAE + SrcBE;
         3'b001:  ALUResultE = SrcAE - SrcBE;
         3'b010:  ALUResultE = SrcAE & SrcBE;
         3'b011:  ALUResultE = SrcAE | SrcBE;
         3'b100:  ALUResultE = SrcAE ^ SrcBE;
         3'b101:  ALUResultE = {{(WIDTH-1){1'b0}}, ($signed(SrcAE) < $signed(SrcBE))};
         3'b110:  ALUResultE = SrcAE << SrcBE[4:0];
         default: ALUResultE = SrcAE >> SrcBE[4:0];
      endcase
   end

   assign ZeroE     = (ALUResultE == '0);
   assign PCTargetE = JALRctrlE ? ((SrcAE + ImmExtE) & ~WIDTH'(1)) : (PCE + ImmExtE);
   assign PCSrcE    = JumpE | (BranchE & ZeroE);

`ifdef EXEC_BRANCH_STATS_EN
   // Counts what was resolved in E this cycle; flush leaves history intact.
   always_ff @(posedge clk) begin
      if (rst) begin
         BranchCountE <= '0;
         TakenCountE  <= '0;
      end else begin
         if (BranchE)
            BranchCountE <= BranchCountE + WIDTH'(1);
         if (BranchE && ZeroE)
            TakenCountE <= TakenCountE + WIDTH'(1);
      end
   end
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Randomized scoreboard bench for execute_stage against a behavioural model.
module tb_execute_stage;

   typedef struct packed {
      logic        rst, flush;
      logic        rw, mw, jmp, br, alusrc, jalr;
      logic [1:0]  rsrc;
      logic [2:0]  op;
      logic [31:0] rd1, rd2, pc, imm, pc4;
      logic [4:0]  rd, rs1, rs2;
      logic [1:0]  fa, fb;
      logic [31:0] alum, resw;
   } txn_t;

   typedef struct packed {
      logic        rw, mw;
      logic [1:0]  rsrc;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] alu, wd, pc4, tgt;
      logic        pcsrc, zero;
      logic [31:0] bc, tc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, JALRctrlD, FlushE;
   logic [1:0]  ResultSrcD, ForwardAE, ForwardBE;
   logic [2:0]  ALUControlD;
   logic [31:0] RD1D, RD2D, PCD, ImmExtD, PCPlus4D, ALUResultM, ResultW;
   logic [4:0]  RdD, Rs1D, Rs2D;
   logic        RegWriteE, MemWriteE, PCSrcE, ZeroE;
   logic [1:0]  ResultSrcE;
   logic [4:0]  RdE, Rs1E, Rs2E;
   logic [31:0] ALUResultE, WriteDataE, PCPlus4E, PCTargetE;
`ifdef EXEC_BRANCH_STATS_EN
   logic [31:0] BranchCountE, TakenCountE;
`endif

   execute_stage #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
      .ALUSrcD(ALUSrcD), .JALRctrlD(JALRctrlD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
      .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .ImmExtD(ImmExtD), .PCPlus4D(PCPlus4D),
      .RdD(RdD), .Rs1D(Rs1D), .Rs2D(Rs2D), .FlushE(FlushE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ALUResultM(ALUResultM), .ResultW(ResultW),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
      .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
      .PCPlus4E(PCPlus4E), .PCTargetE(PCTargetE), .PCSrcE(PCSrcE), .ZeroE(ZeroE)
`ifdef EXEC_BRANCH_STATS_EN
     ,.BranchCountE(BranchCountE), .TakenCountE(TakenCountE)
`endif
   );

   always #5 clk = ~clk;

   int   tests = 0;
   int   fails = 0;
   txn_t stim[$];
   exp_t expq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: what the instruction in E should produce, given the forwarding in that cycle.
   function automatic exp_t eval(input txn_t t);
      exp_t        e;
      txn_t        v;
      logic [31:0] a, b, sb, r;
      v = t;
      if (t.rst || t.flush) begin
         v = '0;
         v.fa = t.fa; v.fb = t.fb; v.alum = t.alum; v.resw = t.resw;
      end
      a  = (v.fa == 2'd1) ? v.resw : (v.fa == 2'd2) ? v.alum : v.rd1;
      b  = (v.fb == 2'd1) ? v.resw : (v.fb == 2'd2) ? v.alum : v.rd2;
      sb = v.alusrc ? v.imm : b;
      case (v.op)
         3'd0: r = a + sb;
         3'd1: r = a - sb;
         3'd2: r = a & sb;
         3'd3: r = a | sb;
         3'd4: r = a ^ sb;
         3'd5: r = (int'(a) < int'(sb)) ? 32'd1 : 32'd0;
         3'd6: r = a << (sb % 32);
         default: r = a >> (sb % 32);
      endcase
      e       = '0;
      e.rw    = v.rw;  e.mw = v.mw; e.rsrc = v.rsrc;
      e.rd    = v.rd;  e.rs1 = v.rs1; e.rs2 = v.rs2;
      e.alu   = r;     e.wd = b;  e.pc4 = v.pc4;
      e.zero  = (r == 32'd0);
      e.tgt   = v.jalr ? ((a + v.imm) / 2 * 2) : (v.pc + v.imm);
      e.pcsrc = v.jmp || (v.br && e.zero);
      return e;
   endfunction

   function automatic txn_t rand_txn();
      txn_t t;
      t = '0;
      t.rst  = ($urandom_range(0, 31) == 0);
      t.flush = ($urandom_range(0, 15) == 0);
      t.rw = 1'($urandom); t.mw = 1'($urandom); t.jmp = ($urandom_range(0, 5) == 0);
      t.br = 1'($urandom); t.alusrc = 1'($urandom); t.jalr = 1'($urandom);
      t.rsrc = 2'($urandom); t.op = 3'($urandom);
      t.rd1 = $urandom; t.rd2 = ($urandom_range(0, 2) == 0) ? t.rd1 : $urandom;
      t.pc = $urandom; t.imm = $urandom; t.pc4 = $urandom;
      t.rd = 5'($urandom); t.rs1 = 5'($urandom); t.rs2 = 5'($urandom);
      t.fa = 2'($urandom); t.fb = 2'($urandom); t.alum = $urandom; t.resw = $urandom;
      return t;
   endfunction

   task automatic drive_d(input txn_t t);
      rst = t.rst; FlushE = t.flush;
      RegWriteD = t.rw; MemWriteD = t.mw; JumpD = t.jmp; BranchD = t.br;
      ALUSrcD = t.alusrc; JALRctrlD = t.jalr; ResultSrcD = t.rsrc; ALUControlD = t.op;
      RD1D = t.rd1; RD2D = t.rd2; PCD = t.pc; ImmExtD = t.imm; PCPlus4D = t.pc4;
      RdD = t.rd; Rs1D = t.rs1; Rs2D = t.rs2;
   endtask

   task automatic drive_fwd(input txn_t t);
      ForwardAE = t.fa; ForwardBE = t.fb; ALUResultM = t.alum; ResultW = t.resw;
   endtask

   function automatic txn_t quiet(input txn_t t);
      txn_t q;
      q = t;
      q.rst = 1'b0; q.flush = 1'b0; q.fa = 2'd0; q.fb = 2'd0;
      q.jmp = 1'b0; q.br = 1'b0; q.jalr = 1'b0; q.alusrc = 1'b0;
      return q;
   endfunction

   task automatic build();
      txn_t t;
      for (int i = 0; i < 2; i++) begin
         t = rand_txn(); t.rst = 1'b1; t.fa = 2'd0; t.fb = 2'd0; stim.push_back(t);
      end
      t = quiet(rand_txn()); t.op = 3'd1; t.rd1 = 32'd7; t.rd2 = 32'd5; stim.push_back(t);
      t = quiet(rand_txn()); t.op = 3'd5; t.rd1 = 32'hFFFF_FFFF; t.rd2 = 32'd1; stim.push_back(t);
      t = quiet(rand_txn()); t.op = 3'd0; t.rd1 = 32'd0;
      t.fa = 2'd2; t.alum = 32'h10; t.fb = 2'd1; t.resw = 32'h3; stim.push_back(t);
      t = quiet(rand_txn()); t.br = 1'b1; t.op = 3'd1; t.rd1 = 32'd9; t.rd2 = 32'd9;
      t.pc = 32'h100; t.imm = 32'h20; stim.push_back(t);
      t.rd2 = 32'd8; stim.push_back(t);
      t = quiet(rand_txn()); t.jmp = 1'b1; t.jalr = 1'b1; t.rd1 = 32'h201; t.imm = 32'd4;
      stim.push_back(t);
      t = rand_txn(); t.rst = 1'b0; t.flush = 1'b1; t.rw = 1'b1; t.mw = 1'b1; t.br = 1'b1;
      t.jmp = 1'b1; t.fa = 2'd0; t.fb = 2'd0; stim.push_back(t);
      t.rst = 1'b1; stim.push_back(t);
      for (int i = 0; i < 3; i++) begin
         t = quiet(rand_txn()); t.br = 1'b1; t.op = 3'd1;
         t.rd1 = 32'd4; t.rd2 = (i == 2) ? 32'd5 : 32'd4; stim.push_back(t);
      end
      t = quiet(rand_txn()); stim.push_back(t);
      for (int i = 0; i < 400; i++) stim.push_back(rand_txn());
   endtask

   // Stimulus: drive D for the next entry and forwarding for the entry now in E.
   initial begin
      txn_t        nxt, zero_fwd;
      exp_t        e;
      logic [31:0] bc, tc;
      build();
      zero_fwd = '0;
      drive_d(stim[0]);
      drive_fwd(zero_fwd);
      bc = 32'd0; tc = 32'd0;
      for (int k = 0; k < stim.size(); k++) begin
         @(posedge clk); #1;
         drive_fwd(stim[k]);
         nxt = (k + 1 < stim.size()) ? stim[k+1] : quiet(zero_fwd);
         drive_d(nxt);
         e = eval(stim[k]);
         e.bc = bc; e.tc = tc;
         expq.push_back(e);
         if (nxt.rst) begin
            bc = 32'd0; tc = 32'd0;
         end else if (stim[k].br && !stim[k].rst && !stim[k].flush) begin
            bc = bc + 32'd1;
            if (e.zero) tc = tc + 32'd1;
         end
      end
      @(negedge clk); #1;
      chk("scoreboard_drain", 32'(expq.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Monitor: every cycle E presents one result; compare it against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("RegWriteE",  32'(RegWriteE),  32'(e.rw));
            chk("MemWriteE",  32'(MemWriteE),  32'(e.mw));
            chk("ResultSrcE", 32'(ResultSrcE), 32'(e.rsrc));
            chk("RdE",        32'(RdE),        32'(e.rd));
            chk("Rs1E",       32'(Rs1E),       32'(e.rs1));
            chk("Rs2E",       32'(Rs2E),       32'(e.rs2));
            chk("ALUResultE", ALUResultE,      e.alu);
            chk("WriteDataE", WriteDataE,      e.wd);
            chk("PCPlus4E",   PCPlus4E,        e.pc4);
            chk("PCTargetE",  PCTargetE,       e.tgt);
            chk("PCSrcE",     32'(PCSrcE),     32'(e.pcsrc));
            chk("ZeroE",      32'(ZeroE),      32'(e.zero));
`ifdef EXEC_BRANCH_STATS_EN
            chk("BranchCountE", BranchCountE, e.bc);
            chk("TakenCountE",  TakenCountE,  e.tc);
`endif
         end
      end
   end

endmodule
